// File: rtl/sti_deserializer_if.sv
// STI receive-side bundle: serial input, frame controls and the valid/ready output.
interface sti_deserializer_if;
  logic        si_data;
  logic        si_valid;
  logic [1:0]  si_length;
  logic        si_fill;
  logic        si_msb;
  logic        si_low;
  logic        si_end;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_ready;
  logic        po_pad_err;
  logic        po_frame_err;
  logic        po_overflow;
  logic        po_done;

  // Serial source / downstream consumer side.
  modport master (
    output si_data, si_valid, si_length, si_fill, si_msb, si_low, si_end, po_ready,
    input  po_data, po_valid, po_pad_err, po_frame_err, po_overflow, po_done
  );

  // Deserializer side.
  modport slave (
    input  si_data, si_valid, si_length, si_fill, si_msb, si_low, si_end, po_ready,
    output po_data, po_valid, po_pad_err, po_frame_err, po_overflow, po_done
  );
endinterface

// File: rtl/sti_deserializer.sv
// STI serial-to-parallel receiver: rebuilds 16-bit words from 8/16/24/32-bit frames
// and hands them downstream through a one-deep valid/ready register.
module sti_deserializer (
  input logic               clk,
  input logic               reset,
  sti_deserializer_if.slave sti
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] END  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] frame_q, frame_d;
  logic [1:0]  len_q, len_d;
  logic        fill_q, fill_d;
  logic        msb_q, msb_d;
  logic        low_q, low_d;
  logic        cmpl_q, cmpl_d;
  logic        frame_err_q, frame_err_d;

  logic [15:0] po_data_q;
  logic        po_valid_q;
  logic        pad_err_q;
  logic        overflow_q;
  logic        done_q;

  logic [5:0]  width;
  logic [15:0] word;
  logic        pad;

  // Frame width in bits from the captured length code.
  always_comb begin
    case (len_q)
      2'd0:    width = 6'd8;
      2'd1:    width = 6'd16;
      2'd2:    width = 6'd24;
      default: width = 6'd32;
    endcase
  end

  // Receive FSM; frames are assembled so that frame_q[W-1:0] equals F when complete.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_d     = frame_q;
    len_d       = len_q;
    fill_d      = fill_q;
    msb_d       = msb_q;
    low_d       = low_q;
    cmpl_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sti.si_valid) begin
          len_d   = sti.si_length;
          fill_d  = sti.si_fill;
          msb_d   = sti.si_msb;
          low_d   = sti.si_low;
          // First bit lands in bit 0 for either bit order.
          frame_d = {31'b0, sti.si_data};
          count_d = 6'd1;
          state_d = RECV;
        end else if (sti.si_end) begin
          state_d = END;
        end
      end
      RECV: begin
        if (sti.si_valid) begin
          if (msb_q) begin
            frame_d = {frame_q[30:0], sti.si_data};
          end else begin
            frame_d[count_q[4:0]] = sti.si_data;
          end
          if (count_q + 6'd1 == width) begin
            cmpl_d  = 1'b1;
            count_d = 6'd0;
            state_d = IDLE;
          end else begin
            count_d = count_q + 6'd1;
          end
        end else begin
          frame_err_d = 1'b1;
          count_d     = 6'd0;
          state_d     = IDLE;
        end
      end
      END: begin
        state_d = END;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word and pad extraction from the completed frame (cfg still held for it).
  always_comb begin
    word = frame_q[15:0];
    pad  = 1'b0;
    case (len_q)
      2'd0: word = low_q ? {frame_q[7:0], 8'h00} : {8'h00, frame_q[7:0]};
      2'd1: word = frame_q[15:0];
      2'd2: begin
        word = fill_q ? frame_q[23:8] : frame_q[15:0];
        pad  = fill_q ? |frame_q[7:0] : |frame_q[23:16];
      end
      default: begin
        word = fill_q ? frame_q[31:16] : frame_q[15:0];
        pad  = fill_q ? |frame_q[15:0] : |frame_q[31:16];
      end
    endcase
  end

  // Receive-side state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 6'd0;
      frame_q     <= 32'd0;
      len_q       <= 2'd0;
      fill_q      <= 1'b0;
      msb_q       <= 1'b0;
      low_q       <= 1'b0;
      cmpl_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_q     <= frame_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      msb_q       <= msb_d;
      low_q       <= low_d;
      cmpl_q      <= cmpl_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Output register: load on completion if free or draining, else drop and flag overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      po_data_q  <= 16'h0000;
      po_valid_q <= 1'b0;
      pad_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (cmpl_q) begin
        if (!po_valid_q || sti.po_ready) begin
          po_data_q  <= word;
          pad_err_q  <= pad;
          po_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (po_valid_q && sti.po_ready) begin
        po_valid_q <= 1'b0;
      end
      if (state_q == END && !po_valid_q) begin
        done_q <= 1'b1;
      end
    end
  end

  assign sti.po_data      = po_data_q;
  assign sti.po_valid     = po_valid_q;
  assign sti.po_pad_err   = pad_err_q;
  assign sti.po_frame_err = frame_err_q;
  assign sti.po_overflow  = overflow_q;
  assign sti.po_done      = done_q;

endmodule

// File: doc/sti_deserializer.md
# sti_deserializer

Serial-to-parallel receiver for the STI serial protocol. It accepts the bit stream produced by the STI/DAC serializer (`so_data` / `so_valid`) and rebuilds the original 16-bit parallel words. It uses the same length, fill, bit-order and byte-select controls as the transmitter. The block sits on the receive side of the STI link and hands each recovered word to downstream logic through a one-deep valid/ready output register.

## Interface
Parameters:
- none; widths are fixed by the STI protocol.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `si_data`  in  1  serial data bit; sampled when `si_valid`=1.
- `si_valid`  in  1  serial bit qualifier; stays high for a whole frame.
- `si_length`  in  2  frame width: 00=8, 01=16, 10=24, 11=32 bits.
- `si_fill`  in  1  for 24/32-bit frames: 1 = data in the upper 16 bits of the frame; 0 = data in the lower 16 bits.
- `si_msb`  in  1  1 = frame sent MSB first; 0 = LSB first.
- `si_low`  in  1  8-bit frames only: 1 = byte goes to `po_data[15:8]`; 0 = byte goes to `po_data[7:0]`.
- `si_end`  in  1  end-of-stream pulse.
- `po_data`  out  16  recovered word.
- `po_valid`  out  1  `po_data` holds an unconsumed word.
- `po_ready`  in  1  downstream accepts the word when `po_valid` & `po_ready`.
- `po_pad_err`  out  1  pad bits of the current word were not all zero.
- `po_frame_err`  out  1  one-cycle pulse when a frame is aborted.
- `po_overflow`  out  1  sticky flag: a completed frame was dropped.
- `po_done`  out  1  sticky flag: stream finished and the output is drained.

## Operation
- Frame width W = 8*(`si_length`+1).
- The `si_length`, `si_fill`, `si_msb` and `si_low` values are captured on the first valid bit of a frame and held until that frame completes. Changing them mid-frame has no effect on the current frame.
- Frame word F is W bits wide, with bit W-1 as its most significant bit.
  - If `si_msb`=1, the first received bit is F[W-1].
  - If `si_msb`=0, the first received bit is F[0].
- Word extraction when the frame completes:
  - W=8: the byte is F[7:0]; the other byte of `po_data` is 0.
  - W=16: `po_data` = F[15:0].
  - W=24/32 with fill=1: `po_data` = F[W-1:W-16]; the pad bits are F[W-17:0].
  - W=24/32 with fill=0: `po_data` = F[15:0]; the pad bits are F[W-1:16].
  - `po_pad_err` = OR of the pad bits; it is 0 for W≤16.
- State machine:
  - IDLE:
    - `si_valid`=1 → capture config, store bit, count=1, go to RECV.
    - `si_end`=1 → go to END.
  - RECV:
    - Each `si_valid`=1 cycle stores a bit and increments count.
    - When count reaches W, the frame completes → IDLE.
    - `si_valid`=0 with count<W → abort: pulse `po_frame_err`, clear count, → IDLE.
  - END:
    - `po_done` = ~`po_valid`. Once set, it stays set until reset.
    - Serial input is ignored in END.
- Back-to-back frames: if `si_valid` stays high on the cycle after the last bit, that bit starts a new frame. Config is recaptured on that cycle.
- Output register:
  - On frame completion with `po_valid`=0, or with `po_valid`=1 & `po_ready`=1 in the same cycle: load `po_data` and `po_pad_err`; `po_valid`=1.
  - On frame completion with `po_valid`=1 & `po_ready`=0: drop the new word, set `po_overflow`, keep the old word unchanged.
  - `po_valid` & `po_ready` with no completing frame: `po_valid`→0. `po_data` keeps its last value.
- If `si_end` arrives during RECV, it is ignored.
- Counter: 6 bits, range 0..32; it never wraps.

## Timing
- Bit sampling: `si_data` is captured on the rising edge where `si_valid`=1.
- Latency: the last bit sampled at edge t gives `po_valid`=1 with the new `po_data` after edge t+1. There is no extra latency for back-to-back frames.
- `po_frame_err` is high for exactly the one cycle after the edge at which the abort is detected.
- Reset values: `po_data`=0x0000, `po_valid`=0, `po_pad_err`=0, `po_frame_err`=0, `po_overflow`=0, `po_done`=0, state=IDLE, count=0.
- Reset asserted mid-frame discards the partial frame and the held word. No error flag is raised.
- The earliest valid bit after reset is accepted on the first edge with `reset`=0.

## Test plan
- 16-bit MSB-first frame: length=01, msb=1, bits of 0xA5C3 MSB first, `po_ready`=1 → `po_valid` for 1 cycle, `po_data`=0xA5C3, `po_pad_err`=0.
- 8-bit high-byte frame: length=00, low=1, msb=0, bits 0,0,1,1,1,1,0,0 → `po_data`=0x3C00.
- 32-bit padded frame, two cases:
  - length=11, fill=0, msb=1, 16 zero bits then 0x1234 → `po_data`=0x1234, `po_pad_err`=0.
  - Same frame with the first pad bit set to 1 → `po_pad_err`=1.
- Abort then recover: length=01, `si_valid` drops after 5 bits → one `po_frame_err` pulse, no `po_valid`. A following full frame of 0xBEEF → `po_data`=0xBEEF.
- Overflow: `po_ready`=0, two back-to-back 16-bit frames 0x1111 and 0x2222 → `po_data` stays 0x1111, `po_overflow`=1. Then raise `po_ready` → `po_valid` falls after one accept.
- End and reset:
  - `si_end` pulse while a word is pending → `po_done` rises the cycle after the word is accepted.
  - `reset` asserted mid-frame → all outputs return to their reset values next cycle.
